// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared constants and helpers for the BCD counter / seven-segment
//             display bank: segment patterns, BCD decode, counter widths.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package disp_pkg;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Active-low decode of one BCD digit; non-BCD codes show nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit
//  Purpose  : One BCD decade cell with load and up/down step.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             load/load_nib - load a nibble (values above 9 load as 0)
//             step          - apply a count step this cycle
//             up            - 1 = increment, 0 = decrement
//             cin           - carry/borrow from the lower decade
//             q             - current digit
//             cout          - carry/borrow into the next decade
//             at_term       - digit is 9 (up) or 0 (down)
//  Revision : 1.0  initial release
// ============================================================================
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout,
  output logic       at_term
);

  logic [3:0] r_q;

  assign at_term = up ? (r_q == 4'd9) : (r_q == 4'd0);
  // A decade passes the step on only when it is about to roll over.
  assign cout    = cin & at_term;
  assign q       = r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 4'd0;
    end else if (load) begin
      r_q <= (load_nib > 4'd9) ? 4'd0 : load_nib;
    end else if (step && cin) begin
      if (up) r_q <= (r_q == 4'd9) ? 4'd0 : r_q + 4'd1;
      else    r_q <= (r_q == 4'd0) ? 4'd9 : r_q - 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_mux_disp.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_mux_disp
//  Purpose  : Multi-digit up/down BCD counter with internal tick prescaler,
//             wrap or saturate at the terminal value, and a multiplexed
//             common-anode seven-segment display with optional leading-zero
//             blanking.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             en, up     - count enable, direction
//             load       - synchronous load of load_val (nibble i = digit i)
//             bcd_value  - current count
//             tick       - one-cycle prescaler rollover pulse
//             carry      - one-cycle pulse when a tick hits the terminal value
//             seg        - active-low segments of the selected digit
//             dig_n      - active-low one-hot digit select
//  Revision : 1.0  initial release
// ============================================================================
module bcd_counter_mux_disp
  import disp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_HZ     = 1000,
  parameter int SATURATE    = 0,
  parameter int BLANK_LZ    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] bcd_value,
  output logic                    tick,
  output logic                    carry,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_n
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_FREQ_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int PRESC_W  = cnt_width(TICK_DIV);
  localparam int SDIV_W   = cnt_width(SCAN_DIV);
  localparam int IDX_W    = cnt_width(NUM_DIGITS);

  logic [PRESC_W-1:0]      r_presc;
  logic                    r_tick;
  logic                    r_carry;
  logic [SDIV_W-1:0]       r_sdiv;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_n;

  logic                    w_tick_cond;
  logic                    w_step_req;
  logic                    w_step;
  logic [4*NUM_DIGITS-1:0] w_q;
  logic [NUM_DIGITS-1:0]   w_cin;
  logic [NUM_DIGITS-1:0]   w_cout;
  logic [NUM_DIGITS-1:0]   w_at_term;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS:0]     w_zero_above;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg_next;

  // ---------------- prescaler and count control ----------------
  assign w_tick_cond = en && (r_presc == PRESC_W'(TICK_DIV - 1));
  // The registered tick is the cycle on which the count actually steps.
  assign w_step_req  = r_tick && en;
  // The ripple-out of the top decade means every digit is at its terminal
  // value; in saturate mode that step is swallowed.
  assign w_step      = w_step_req && !((SATURATE != 0) && w_cout[NUM_DIGITS-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_step_req && (&w_at_term);
      r_tick  <= w_tick_cond;
      if (en) r_presc <= w_tick_cond ? '0 : r_presc + 1'b1;
    end
  end

  // ---------------- decade chain ----------------
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign w_cin[k] = 1'b1;
    end else begin : g_upper
      assign w_cin[k] = w_cout[k-1];
    end

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_nib (load_val[4*k +: 4]),
      .step     (w_step),
      .up       (up),
      .cin      (w_cin[k]),
      .q        (w_q[4*k +: 4]),
      .cout     (w_cout[k]),
      .at_term  (w_at_term[k])
    );
  end

  assign bcd_value = w_q;

  // ---------------- scan divider ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdiv <= '0;
      r_idx  <= '0;
    end else if (r_sdiv == SDIV_W'(SCAN_DIV - 1)) begin
      r_sdiv <= '0;
      r_idx  <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_sdiv <= r_sdiv + 1'b1;
    end
  end

  // ---------------- digit mux and blanking ----------------
  always_comb begin
    w_sel        = '0;
    w_sel[r_idx] = 1'b1;
    w_nib        = w_q[4*r_idx +: 4];
    // w_zero_above[k]: digits k and higher are all zero.
    w_zero_above             = '0;
    w_zero_above[NUM_DIGITS] = 1'b1;
    w_blank                  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_above[k] = w_zero_above[k+1] && (w_q[4*k +: 4] == 4'd0);
      w_blank[k]      = (BLANK_LZ != 0) && (k != 0) && w_zero_above[k];
    end
    w_seg_next = w_blank[r_idx] ? SEG_BLANK : bcd_to_seg(w_nib);
  end

  // Select and pattern share one register stage so they never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg   <= SEG_ZERO;
      r_dig_n <= ~NUM_DIGITS'(1);
    end else begin
      r_seg   <= w_seg_next;
      r_dig_n <= ~w_sel;
    end
  end

  assign tick  = r_tick;
  assign carry = r_carry;
  assign seg   = r_seg;
  assign dig_n = r_dig_n;

endmodule
`default_nettype wire
